vga_fb_arbiter: RTL

Shares one single-port framebuffer RAM between the VGA display path and a pixel writer, sitting between the framebuffer and `vga_ctrl`. Display fetch has fixed priority: it keeps a small show-ahead pixel FIFO topped up from the RAM, in raster order. The writer gets every RAM cycle the display does not need, mostly during blanking. The FIFO head drives `vga_data` into `vga_ctrl` whenever `valid` is high.

---
 rtl/vga_fb_pkg.sv | 20 ++
 rtl/vga_fb_arbiter_if.sv | 27 ++
 rtl/vga_pix_fifo.sv | 65 ++++++
 rtl/vga_fb_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg -- shared constants and the pixel type for the framebuffer arbiter.
//   H_RES/V_RES : active raster size
//   FB_PIXELS   : number of framebuffer words holding one frame
//   ADDR_W      : RAM word address width (2**ADDR_W >= FB_PIXELS)
//   DATA_W      : pixel width, packed {r,g,b}
package vga_fb_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if -- framebuffer RAM port plus pixel-writer handshake.
//   master : the arbiter (drives the RAM strobes/address/data and wr_ack)
//   slave  : the environment (RAM returns mem_rdata, writer drives wr_req/wr_addr/wr_data)
interface vga_fb_arbiter_if;
  import vga_fb_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (
    output mem_addr, mem_rd, mem_we, mem_wdata, wr_ack,
    input  mem_rdata, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  mem_addr, mem_rd, mem_we, mem_wdata, wr_ack,
    output mem_rdata, wr_req, wr_addr, wr_data
  );

endinterface

// File: rtl/vga_pix_fifo.sv
// vga_pix_fifo -- synchronous show-ahead pixel FIFO.
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write din (caller never pushes when full)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   dout       : current head entry (valid when count != 0)
//   count      : occupancy, 0..DEPTH
module vga_pix_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  pixel_t           din,
  output pixel_t           dout,
  output logic [CNT_W-1:0] count
);

  pixel_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;

  assign push_s = push && !flush;
  assign pop_s  = pop && !flush && (count_r != CNT_W'(0));
  assign dout   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= PTR_W'(0);
      wr_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      rd_ptr_r <= PTR_W'(0);
      wr_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter -- shares one single-port framebuffer RAM between display
// fetch (fixed priority, keeps a pixel FIFO topped up in raster order) and a
// pixel writer that gets every cycle the display does not need.
//   pclk, reset : pixel clock, asynchronous active-high reset
//   vsync       : low during vertical sync; restarts the fetch at address 0
//   valid       : active-pixel strobe from vga_ctrl, one pop per cycle
//   vga_data    : FIFO head while popping, else 0
//   underrun    : sticky, valid seen with an empty FIFO
//   bus         : RAM port and writer handshake (master side)
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              valid,
  output logic [DATA_W-1:0] vga_data,
  output logic              underrun,
  vga_fb_arbiter_if.master  bus
);

  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] FB_END  = ADDR_W'(FB_PIXELS);
  localparam logic [CNT_W:0]    DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fill_addr_r;
  logic              inflight_r;
  logic              discard_r;
  logic              underrun_r;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W:0]    occ_s;
  logic              demand_s;
  logic              push_s;
  logic              pop_s;
  pixel_t            head_s;

  // In-flight reads count as occupied so a return can never overflow the FIFO.
  assign occ_s    = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r};
  assign demand_s = !reset && vsync && (occ_s < DEPTH_W) && (fill_addr_r < FB_END);
  assign push_s   = inflight_r && !discard_r;
  assign pop_s    = valid && (count_s != CNT_W'(0));
  assign underrun = underrun_r;

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pclk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (!vsync),
    .din   (pixel_t'(bus.mem_rdata)),
    .dout  (head_s),
    .count (count_s)
  );

  // RAM arbitration: display demand first, writer otherwise, else idle.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.wr_ack    = 1'b0;
    if (demand_s) begin
      bus.mem_rd   = 1'b1;
      bus.mem_addr = fill_addr_r;
    end else if (!reset && bus.wr_req) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
      bus.wr_ack    = 1'b1;
    end else begin
      bus.mem_rd = 1'b0;
    end
  end

  // Pixel out: head of the FIFO only on a real pop.
  always_comb begin
    vga_data = {DATA_W{1'b0}};
    if (pop_s) begin
      vga_data = head_s;
    end else begin
      vga_data = {DATA_W{1'b0}};
    end
  end

  // Fill counter, in-flight/discard tracking and the sticky underrun flag.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      fill_addr_r <= {ADDR_W{1'b0}};
      inflight_r  <= 1'b0;
      discard_r   <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      inflight_r <= demand_s;
      if (!vsync) begin
        fill_addr_r <= {ADDR_W{1'b0}};
        discard_r   <= inflight_r;
      end else begin
        // demand_s already excludes FB_END, so the counter saturates there.
        if (demand_s) fill_addr_r <= fill_addr_r + ADDR_W'(1);
        // Any return arriving now is the one being dropped; later ones are fresh.
        discard_r <= 1'b0;
      end
      if (valid && (count_s == CNT_W'(0))) underrun_r <= 1'b1;
    end
  end

endmodule
